axi_rw_latency_monitor: RTL and testbench
=========================================

AXI_RW_LATENCY_MONITOR -- requirements
Module: axi_rw_latency_monitor

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, register bus data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 5, register byte-address width.
REQ-003 Parameter NUM_CH, default 2, number of monitored AXI4-Lite links; legal range 1..4.
REQ-004 Parameter CNT_WIDTH, default 32, latency/count width; legal range 8..32; register reads zero-extend.
REQ-005 The clock port SHALL be s00_axi_aclk (input, 1 bit); the whole block runs on this single clock.
REQ-006 The reset port SHALL be s00_axi_aresetn (input, 1 bit); reset is asynchronous and active-low.
REQ-007 s00_axi_awaddr/awprot/awvalid/awready: in/in/in/out, ADDR_W/3/1/1, register write address; awprot is ignored.
REQ-008 s00_axi_wdata/wstrb/wvalid/wready: in/in/in/out, 32/4/1/1, register write data.
REQ-009 s00_axi_bresp/bvalid/bready: out/out/in, 2/1/1, register write response.
REQ-010 s00_axi_araddr/arprot/arvalid/arready: in/in/in/out, ADDR_W/3/1/1, register read address; arprot is ignored.
REQ-011 s00_axi_rdata/rresp/rvalid/rready: out/out/out/in, 32/2/1/1, register read data.
REQ-012 mon_awvalid, mon_awready, mon_bvalid, mon_bready: inputs, NUM_CH each, snooped write handshakes; bit i is link i.
REQ-013 mon_arvalid, mon_arready, mon_rvalid, mon_rready: inputs, NUM_CH each, snooped read handshakes.

Function
REQ-014 Register slave: awready and wready pulse high together for 1 cycle when awvalid, wvalid and !bvalid are all high; bvalid is set the next cycle and held until bready; bresp is always 00.
REQ-015 Register reads: arready pulses for 1 cycle when arvalid and !rvalid; rvalid is set the next cycle and held until rready; rresp is 00; unmapped offsets read 0.
REQ-016 Register map: 0x00 CTRL RW, with bit0 ENABLE, bit1 CLEAR (write-1, self-clearing, reads 0) and bits[9:8] CH_SEL; CH_SEL values at or above NUM_CH read back as, and act as, 0.
REQ-017 0x04 STATUS, write-1-to-clear: bits[3:0] WR_OVERLAP[ch] and bits[11:8] RD_OVERLAP[ch], all sticky.
REQ-018 Channel registers for CH_SEL, all RO: 0x08 WR_LAST, 0x0C WR_MAX, 0x10 WR_CNT, 0x14 RD_LAST, 0x18 RD_MAX, 0x1C RD_CNT.
REQ-019 Each channel and direction has its own FSM with states IDLE and BUSY.
REQ-020 IDLE->BUSY on a start handshake (awvalid&awready, or arvalid&arready) while ENABLE=1; the timer loads 0.
REQ-021 In BUSY the timer increments by 1 each cycle and saturates at 2^CNT_WIDTH-1.
REQ-022 BUSY->IDLE on an end handshake (bvalid&bready, or rvalid&rready); LAST<=timer+1 (saturating); MAX<=max(MAX, timer+1); CNT<=CNT+1 (saturating).
REQ-023 Start and end handshakes in the same cycle while IDLE record a latency of 0 and increment CNT; the FSM stays IDLE.
REQ-024 A start handshake while BUSY sets the OVERLAP bit; the timer is not restarted.
REQ-025 An end handshake while IDLE is ignored.
REQ-026 Clearing ENABLE does not abort a BUSY measurement; it completes normally.
REQ-027 CLEAR zeroes LAST, MAX, CNT and timers, and forces all FSMs to IDLE, on the cycle after the write; it takes priority over a completion in the same cycle. STATUS is unaffected.
REQ-028 A register read returns values as of the arready cycle; a completion in that same cycle is not visible.

Reset
REQ-029 Asynchronous assertion forces all FSMs to IDLE; CTRL, STATUS, LAST, MAX, CNT and timers to 0; awready, wready, bvalid, arready and rvalid to 0; bresp, rresp and rdata to 0.
REQ-030 Reset asserted mid-measurement discards it; the first handshake after deassertion is evaluated from IDLE.

Verification
REQ-031 Write CTRL=0x1; on link 0, AW handshake at cycle t, B handshake at t+7 -> WR_LAST=7, WR_MAX=7, WR_CNT=1.
REQ-032 Then RD latencies 3, 10, 5 on link 1 with CH_SEL=1 -> RD_LAST=5, RD_MAX=10, RD_CNT=3; link 0 RD_CNT=0.
REQ-033 A second AR on link 0 while BUSY -> STATUS=0x100; writing STATUS=0x100 -> reads 0x0; the first measurement still completes with the correct latency.
REQ-034 ENABLE=0, then AW/B on link 0 -> counters unchanged; ENABLE cleared while BUSY -> that measurement is still recorded.
REQ-035 CNT_WIDTH=8, a B response 300 cycles after AW -> WR_LAST=0xFF, WR_MAX=0xFF.
REQ-036 Write CTRL=0x3 during a BUSY whose B handshake lands in the same cycle -> all channel registers read 0; CTRL reads 0x1.

Source files
------------

// File: rtl/axi_rw_latency_monitor.sv
// ---------------------------------------------------------------------------
// axi_rw_latency_monitor
//
// Purpose:
//   Snoops the handshake signals of NUM_CH AXI4-Lite links and measures, per
//   link and per direction, the number of cycles from the address handshake
//   (AW or AR) to the response handshake (B or R). For each link/direction it
//   keeps the last latency, the maximum latency and a completion count, plus
//   sticky overlap flags for a new request arriving while one is in flight.
//   Results are read through a small AXI4-Lite register slave.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn  single clock, async active-low reset
//   s00_axi_aw* / w* / b*           register write channel (awprot ignored)
//   s00_axi_ar* / r*                register read channel  (arprot ignored)
//   mon_aw*/mon_b*/mon_ar*/mon_r*   snooped handshakes, bit i = link i
//   dbg_busy                        FSM state per unit: [NUM_CH-1:0] write
//                                   links, [2*NUM_CH-1:NUM_CH] read links
//
// Register map (byte offsets):
//   0x00 CTRL    bit0 ENABLE, bit1 CLEAR (self-clearing), bits[9:8] CH_SEL
//   0x04 STATUS  W1C, bits[3:0] WR_OVERLAP, bits[11:8] RD_OVERLAP
//   0x08 WR_LAST 0x0C WR_MAX 0x10 WR_CNT 0x14 RD_LAST 0x18 RD_MAX 0x1C RD_CNT
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. The slave raises awready/wready (or arready) for
// exactly one cycle; the response valid then stays high until its ready.
// ---------------------------------------------------------------------------
module axi_rw_latency_monitor #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_CH             = 2,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic [NUM_CH-1:0]                 mon_awvalid,
    input  logic [NUM_CH-1:0]                 mon_awready,
    input  logic [NUM_CH-1:0]                 mon_bvalid,
    input  logic [NUM_CH-1:0]                 mon_bready,
    input  logic [NUM_CH-1:0]                 mon_arvalid,
    input  logic [NUM_CH-1:0]                 mon_arready,
    input  logic [NUM_CH-1:0]                 mon_rvalid,
    input  logic [NUM_CH-1:0]                 mon_rready,
    output logic [2*NUM_CH-1:0]               dbg_busy
);

    // One measurement unit per link and direction: writes first, then reads.
    localparam int NU = 2 * NUM_CH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // -----------------------------------------------------------------------
    // Register bus decode
    // -----------------------------------------------------------------------
    logic       wr_hs, rd_hs;
    logic [2:0] wr_word, rd_word;
    logic       wr_hit, rd_hit;
    logic       ctrl_wr, status_wr, clear_now;

    assign wr_hs   = s00_axi_awready & s00_axi_awvalid & s00_axi_wready & s00_axi_wvalid;
    assign rd_hs   = s00_axi_arready & s00_axi_arvalid;
    assign wr_word = s00_axi_awaddr[4:2];
    assign rd_word = s00_axi_araddr[4:2];
    // Offsets above 0x1F (only possible with a wider address) are unmapped.
    assign wr_hit  = (s00_axi_awaddr >> 5) == '0;
    assign rd_hit  = (s00_axi_araddr >> 5) == '0;

    assign ctrl_wr   = wr_hs & wr_hit & (wr_word == 3'd0);
    assign status_wr = wr_hs & wr_hit & (wr_word == 3'd1);
    // CLEAR is never stored; it acts on the edge that completes the write.
    assign clear_now = ctrl_wr & s00_axi_wstrb[0] & s00_axi_wdata[1];

    // -----------------------------------------------------------------------
    // CTRL / STATUS
    // -----------------------------------------------------------------------
    logic              enable;
    logic [1:0]        ch_sel;
    logic [NUM_CH-1:0] wr_ovl, rd_ovl;
    logic [NUM_CH-1:0] wr_ovl_clr, rd_ovl_clr;
    logic [NU-1:0]     start_hs, end_hs, ovl_set;

    assign wr_ovl_clr = (status_wr & s00_axi_wstrb[0]) ? s00_axi_wdata[NUM_CH-1:0] : '0;
    assign rd_ovl_clr = (status_wr & s00_axi_wstrb[1]) ? s00_axi_wdata[8 +: NUM_CH] : '0;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            enable <= 1'b0;
            ch_sel <= 2'd0;
            wr_ovl <= '0;
            rd_ovl <= '0;
        end else begin
            if (ctrl_wr && s00_axi_wstrb[0]) begin
                enable <= s00_axi_wdata[0];
            end
            // Out-of-range channel selections are stored as 0.
            if (ctrl_wr && s00_axi_wstrb[1]) begin
                ch_sel <= (32'(s00_axi_wdata[9:8]) < 32'(NUM_CH)) ? s00_axi_wdata[9:8] : 2'd0;
            end
            // A new overlap in the same cycle as a W1C wins (flag stays set).
            wr_ovl <= (wr_ovl & ~wr_ovl_clr) | ovl_set[NUM_CH-1:0];
            rd_ovl <= (rd_ovl & ~rd_ovl_clr) | ovl_set[NU-1:NUM_CH];
        end
    end

    // -----------------------------------------------------------------------
    // Measurement units
    // -----------------------------------------------------------------------
    assign start_hs = {mon_arvalid & mon_arready, mon_awvalid & mon_awready};
    assign end_hs   = {mon_rvalid & mon_rready, mon_bvalid & mon_bready};

    logic [CNT_WIDTH-1:0] last_a [NU];
    logic [CNT_WIDTH-1:0] max_a  [NU];
    logic [CNT_WIDTH-1:0] cnt_a  [NU];

    for (genvar u = 0; u < NU; u++) begin : g_unit
        state_t               state_q, state_d;
        logic [CNT_WIDTH-1:0] timer_q, last_q, max_q, cnt_q;
        logic [CNT_WIDTH-1:0] timer_inc, lat;
        logic                 rec;

        // timer_q counts completed BUSY cycles, so timer+1 is the latency.
        assign timer_inc = (timer_q == CNT_MAX) ? timer_q : timer_q + 1'b1;

        always_comb begin
            state_d = state_q;
            rec     = 1'b0;
            lat     = '0;
            case (state_q)
                IDLE: begin
                    if (start_hs[u] && enable) begin
                        if (end_hs[u]) begin
                            rec = 1'b1;        // zero-latency transfer
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (end_hs[u]) begin
                        rec     = 1'b1;
                        lat     = timer_inc;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (clear_now) begin
                state_d = IDLE;
                rec     = 1'b0;
            end
        end

        always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
            if (!s00_axi_aresetn) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
            if (!s00_axi_aresetn) begin
                timer_q <= '0;
                last_q  <= '0;
                max_q   <= '0;
                cnt_q   <= '0;
            end else if (clear_now) begin
                timer_q <= '0;
                last_q  <= '0;
                max_q   <= '0;
                cnt_q   <= '0;
            end else begin
                // Held at 0 while idle, so a start always begins from 0.
                timer_q <= (state_q == BUSY) ? timer_inc : '0;
                if (rec) begin
                    last_q <= lat;
                    if (lat > max_q) begin
                        max_q <= lat;
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end

        // A request arriving mid-measurement is flagged, not restarted.
        assign ovl_set[u]  = (state_q == BUSY) & start_hs[u];
        assign dbg_busy[u] = (state_q == BUSY);
        assign last_a[u]   = last_q;
        assign max_a[u]    = max_q;
        assign cnt_a[u]    = cnt_q;
    end

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic [CNT_WIDTH-1:0] s_wl, s_wm, s_wc, s_rl, s_rm, s_rc;

    always_comb begin
        s_wl = '0;
        s_wm = '0;
        s_wc = '0;
        s_rl = '0;
        s_rm = '0;
        s_rc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 2'(i)) begin
                s_wl = last_a[i];
                s_wm = max_a[i];
                s_wc = cnt_a[i];
                s_rl = last_a[i + NUM_CH];
                s_rm = max_a[i + NUM_CH];
                s_rc = cnt_a[i + NUM_CH];
            end
        end
        rd_mux = '0;
        if (rd_hit) begin
            case (rd_word)
                3'd0: begin
                    rd_mux[0]   = enable;
                    rd_mux[9:8] = ch_sel;
                end
                3'd1: begin
                    rd_mux[NUM_CH-1:0]  = wr_ovl;
                    rd_mux[8 +: NUM_CH] = rd_ovl;
                end
                3'd2:    rd_mux = C_S_AXI_DATA_WIDTH'(s_wl);
                3'd3:    rd_mux = C_S_AXI_DATA_WIDTH'(s_wm);
                3'd4:    rd_mux = C_S_AXI_DATA_WIDTH'(s_wc);
                3'd5:    rd_mux = C_S_AXI_DATA_WIDTH'(s_rl);
                3'd6:    rd_mux = C_S_AXI_DATA_WIDTH'(s_rm);
                3'd7:    rd_mux = C_S_AXI_DATA_WIDTH'(s_rc);
                default: rd_mux = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Register slave handshakes
    // -----------------------------------------------------------------------
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            // The !ready term limits each ready to a single-cycle pulse.
            s00_axi_awready <= !s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid;
            s00_axi_wready  <= !s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid;
            if (wr_hs) begin
                s00_axi_bvalid <= 1'b1;
            end else if (s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
            s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;
            // Data is captured on the address handshake, so a completion on
            // that same edge is not yet visible.
            if (rd_hs) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;

    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                         s00_axi_wdata, s00_axi_awaddr, s00_axi_araddr};

endmodule

// File: tb/tb_axi_rw_latency_monitor.sv
// ---------------------------------------------------------------------------
// tb_axi_rw_latency_monitor
//
// Drives the register slave and the snooped link handshakes of
// axi_rw_latency_monitor (NUM_CH=2, CNT_WIDTH=8) and compares every register
// read against a transaction-level model: each measured transfer is reduced
// to (direction, link, latency) and folded into last/max/count arrays.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi_rw_latency_monitor;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [NUM_CH-1:0] mon_awvalid = '0, mon_awready = '0, mon_bvalid = '0, mon_bready = '0;
    logic [NUM_CH-1:0] mon_arvalid = '0, mon_arready = '0, mon_rvalid = '0, mon_rready = '0;
    logic [2*NUM_CH-1:0] dbg_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] exp_q[$];

    axi_rw_latency_monitor #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_W)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .mon_awvalid(mon_awvalid), .mon_awready(mon_awready),
        .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
        .mon_arvalid(mon_arvalid), .mon_arready(mon_arready),
        .mon_rvalid(mon_rvalid), .mon_rready(mon_rready),
        .dbg_busy(dbg_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Index [dir][link], dir 0 = write, 1 = read.
    int m_last [2][NUM_CH];
    int m_max  [2][NUM_CH];
    int m_cnt  [2][NUM_CH];
    bit m_ovl  [2][NUM_CH];
    int m_en  = 0;
    int m_sel = 0;

    function automatic void model_clear();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NUM_CH; c++) begin
                m_last[d][c] = 0;
                m_max[d][c]  = 0;
                m_cnt[d][c]  = 0;
            end
    endfunction

    function automatic void model_reset();
        model_clear();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NUM_CH; c++) m_ovl[d][c] = 1'b0;
        m_en  = 0;
        m_sel = 0;
    endfunction

    function automatic void model_rec(int d, int c, int lat);
        int l;
        l = (lat > MAXV) ? MAXV : lat;
        m_last[d][c] = l;
        if (l > m_max[d][c]) m_max[d][c] = l;
        if (m_cnt[d][c] < MAXV) m_cnt[d][c]++;
    endfunction

    function automatic int model_reg(int off);
        int s;
        s = 0;
        case (off)
            0:  return (m_sel << 8) | m_en;
            4: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (m_ovl[0][c]) s = s | (1 << c);
                    if (m_ovl[1][c]) s = s | (1 << (8 + c));
                end
                return s;
            end
            8:  return m_last[0][m_sel];
            12: return m_max[0][m_sel];
            16: return m_cnt[0][m_sel];
            20: return m_last[1][m_sel];
            24: return m_max[1][m_sel];
            28: return m_cnt[1][m_sel];
            default: return 0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data);
        int n;
        awaddr = addr; wdata = data; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        total++;
        if (!(awready && wready)) begin
            bad++;
            $display("FAIL axi_write_ready addr=%h got=%b%b want=11", addr, awready, wready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        total++;
        if (!bvalid || bresp !== 2'b00) begin
            bad++;
            $display("FAIL axi_write_bresp addr=%h got bvalid=%b bresp=%b want 1/00", addr, bvalid, bresp);
        end
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] d);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        total++;
        if (!arready) begin
            bad++;
            $display("FAIL axi_read_arready addr=%h got=0 want=1", addr);
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        d = rdata;
        total++;
        if (!rvalid || rresp !== 2'b00) begin
            bad++;
            $display("FAIL axi_read_rresp addr=%h got rvalid=%b rresp=%b want 1/00", addr, rvalid, rresp);
        end
        @(negedge clk);
    endtask

    task automatic set_start(input int d, input int c, input bit v, input bit r);
        if (d == 0) begin mon_awvalid[c] = v; mon_awready[c] = r; end
        else        begin mon_arvalid[c] = v; mon_arready[c] = r; end
    endtask

    task automatic set_end(input int d, input int c, input bit v, input bit r);
        if (d == 0) begin mon_bvalid[c] = v; mon_bready[c] = r; end
        else        begin mon_rvalid[c] = v; mon_rready[c] = r; end
    endtask

    // One snooped transfer with `lat` cycles between the start and end
    // handshakes, optionally preceded by valid-without-ready cycles.
    task automatic mon_txn(input int d, input int c, input int lat);
        if ($urandom_range(0, 1) == 1) begin
            set_start(d, c, 1'b1, 1'b0);
            @(negedge clk);
        end
        set_start(d, c, 1'b1, 1'b1);
        if (lat == 0) set_end(d, c, 1'b1, 1'b1);
        @(negedge clk);
        set_start(d, c, 1'b0, 1'b0);
        if (lat == 0) begin
            set_end(d, c, 1'b0, 1'b0);
        end else begin
            if (lat >= 2) begin
                repeat (lat - 2) @(negedge clk);
                set_end(d, c, 1'b1, 1'b0);
                @(negedge clk);
            end
            set_end(d, c, 1'b1, 1'b1);
            @(negedge clk);
            set_end(d, c, 1'b0, 1'b0);
        end
        if (m_en != 0) model_rec(d, c, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        total++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rresp} !== 9'b0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%b rdata=%h want=0", {awready, wready, bvalid, arready, rvalid, bresp, rresp}, rdata);
        end
        total++;
        if (dbg_busy !== '0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", dbg_busy);
        end
        for (int off = 0; off < 32; off += 4) begin
            axi_read(5'(off), d);
            total++;
            if (d !== 32'(model_reg(off))) begin
                bad++;
                $display("FAIL reset_reg off=%0h got=%h want=%h", off, d, model_reg(off));
            end
        end
    endtask

    task automatic test_ctrl();
        logic [31:0] d;
        logic [31:0] wv [3];
        wv[0] = 32'h001; wv[1] = 32'h301; wv[2] = 32'h103;
        for (int i = 0; i < 3; i++) begin
            axi_write(5'h00, wv[i]);
            m_en = int'(wv[i][0]);
            m_sel = (wv[i][9:8] < NUM_CH) ? int'(wv[i][9:8]) : 0;
            if (wv[i][1]) model_clear();
            axi_read(5'h00, d);
            total++;
            if (d !== 32'(model_reg(0))) begin
                bad++;
                $display("FAIL ctrl_readback wrote=%h got=%h want=%h", wv[i], d, model_reg(0));
            end
        end
        axi_write(5'h00, 32'h001);
        m_en = 1; m_sel = 0;
    endtask

    task automatic test_wr_basic();
        logic [31:0] d;
        mon_txn(0, 0, 7);
        for (int off = 8; off <= 16; off += 4) begin
            axi_read(5'(off), d);
            total++;
            if (d !== 32'(model_reg(off))) begin
                bad++;
                $display("FAIL wr_basic off=%0h got=%h want=%h", off, d, model_reg(off));
            end
        end
    endtask

    task automatic test_rd_ch1();
        logic [31:0] d;
        mon_txn(1, 1, 3);
        mon_txn(1, 1, 10);
        mon_txn(1, 1, 5);
        axi_write(5'h00, 32'h101);
        m_sel = 1;
        for (int off = 20; off <= 28; off += 4) begin
            axi_read(5'(off), d);
            total++;
            if (d !== 32'(model_reg(off))) begin
                bad++;
                $display("FAIL rd_ch1 off=%0h got=%h want=%h", off, d, model_reg(off));
            end
        end
        axi_write(5'h00, 32'h001);
        m_sel = 0;
        axi_read(5'h1C, d);
        total++;
        if (d !== 32'(model_reg(28))) begin
            bad++;
            $display("FAIL rd_ch0_cnt got=%h want=%h", d, model_reg(28));
        end
    endtask

    task automatic test_overlap();
        logic [31:0] d;
        int s, e;
        s = cyc;
        set_start(1, 0, 1'b1, 1'b1);
        @(negedge clk);
        set_start(1, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        set_start(1, 0, 1'b1, 1'b1);
        @(negedge clk);
        set_start(1, 0, 1'b0, 1'b0);
        m_ovl[1][0] = 1'b1;
        total++;
        if (dbg_busy[NUM_CH] !== 1'b1) begin
            bad++;
            $display("FAIL overlap_busy got=%b want=1", dbg_busy[NUM_CH]);
        end
        axi_read(5'h04, d);
        total++;
        if (d !== 32'(model_reg(4))) begin
            bad++;
            $display("FAIL overlap_status got=%h want=%h", d, model_reg(4));
        end
        axi_write(5'h04, 32'h100);
        m_ovl[1][0] = 1'b0;
        axi_read(5'h04, d);
        total++;
        if (d !== 32'(model_reg(4))) begin
            bad++;
            $display("FAIL overlap_w1c got=%h want=%h", d, model_reg(4));
        end
        e = cyc;
        set_end(1, 0, 1'b1, 1'b1);
        @(negedge clk);
        set_end(1, 0, 1'b0, 1'b0);
        model_rec(1, 0, e - s);
        for (int off = 20; off <= 28; off += 4) begin
            axi_read(5'(off), d);
            total++;
            if (d !== 32'(model_reg(off))) begin
                bad++;
                $display("FAIL overlap_lat off=%0h got=%h want=%h", off, d, model_reg(off));
            end
        end
    endtask

    task automatic test_enable();
        logic [31:0] d;
        int s, e;
        axi_write(5'h00, 32'h000);
        m_en = 0;
        mon_txn(0, 0, 4);
        axi_write(5'h00, 32'h001);
        m_en = 1;
        s = cyc;
        set_start(0, 0, 1'b1, 1'b1);
        @(negedge clk);
        set_start(0, 0, 1'b0, 1'b0);
        axi_write(5'h00, 32'h000);
        m_en = 0;
        e = cyc;
        set_end(0, 0, 1'b1, 1'b1);
        @(negedge clk);
        set_end(0, 0, 1'b0, 1'b0);
        model_rec(0, 0, e - s);
        for (int off = 8; off <= 16; off += 4) begin
            axi_read(5'(off), d);
            total++;
            if (d !== 32'(model_reg(off))) begin
                bad++;
                $display("FAIL enable off=%0h got=%h want=%h", off, d, model_reg(off));
            end
        end
        axi_write(5'h00, 32'h001);
        m_en = 1;
    endtask

    task automatic test_saturate();
        logic [31:0] d;
        mon_txn(0, 0, 300);
        for (int off = 8; off <= 16; off += 4) begin
            axi_read(5'(off), d);
            total++;
            if (d !== 32'(model_reg(off))) begin
                bad++;
                $display("FAIL saturate off=%0h got=%h want=%h", off, d, model_reg(off));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] want;
        int dir, ch, lat, base;
        for (int it = 0; it < 30; it++) begin
            dir = $urandom_range(0, 1);
            ch  = $urandom_range(0, NUM_CH - 1);
            lat = $urandom_range(0, 20);
            if ($urandom_range(0, 4) == 0) m_en = (m_en == 0) ? 1 : 0;
            axi_write(5'h00, 32'((ch << 8) | m_en));
            m_sel = ch;
            mon_txn(dir, ch, lat);
            base = (dir == 0) ? 8 : 20;
            for (int k = 0; k < 3; k++) exp_q.push_back(32'(model_reg(base + 4 * k)));
            for (int k = 0; k < 3; k++) begin
                axi_read(5'(base + 4 * k), d);
                want = exp_q.pop_front();
                total++;
                if (d !== want) begin
                    bad++;
                    $display("FAIL random it=%0d dir=%0d ch=%0d lat=%0d off=%0h got=%h want=%h",
                             it, dir, ch, lat, base + 4 * k, d, want);
                end
            end
        end
        axi_write(5'h00, 32'h001);
        m_en = 1; m_sel = 0;
    endtask

    task automatic test_clear_race();
        logic [31:0] d;
        int n;
        set_start(0, 0, 1'b1, 1'b1);
        @(negedge clk);
        set_start(0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        awaddr = 5'h00; wdata = 32'h003; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        total++;
        if (!awready) begin
            bad++;
            $display("FAIL clear_race_awready got=0 want=1");
        end
        set_end(0, 0, 1'b1, 1'b1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        set_end(0, 0, 1'b0, 1'b0);
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        m_en = 1; m_sel = 0;
        model_clear();
        total++;
        if (dbg_busy !== '0) begin
            bad++;
            $display("FAIL clear_race_busy got=%b want=0", dbg_busy);
        end
        axi_read(5'h00, d);
        total++;
        if (d !== 32'(model_reg(0))) begin
            bad++;
            $display("FAIL clear_race_ctrl got=%h want=%h", d, model_reg(0));
        end
        for (int sel = 0; sel < NUM_CH; sel++) begin
            axi_write(5'h00, 32'((sel << 8) | 1));
            m_sel = sel;
            for (int off = 4; off < 32; off += 4) begin
                axi_read(5'(off), d);
                total++;
                if (d !== 32'(model_reg(off))) begin
                    bad++;
                    $display("FAIL clear_race sel=%0d off=%0h got=%h want=%h", sel, off, d, model_reg(off));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        set_start(0, 1, 1'b1, 1'b1);
        @(negedge clk);
        set_start(0, 1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (dbg_busy !== '0 || {awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_async busy=%b bus=%b want 0/0", dbg_busy, {awready, wready, bvalid, arready, rvalid});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        axi_read(5'h00, d);
        total++;
        if (d !== 32'(model_reg(0))) begin
            bad++;
            $display("FAIL reset_mid_ctrl got=%h want=%h", d, model_reg(0));
        end
        axi_write(5'h00, 32'h101);
        m_en = 1; m_sel = 1;
        set_end(0, 1, 1'b1, 1'b1);
        @(negedge clk);
        set_end(0, 1, 1'b0, 1'b0);
        for (int off = 8; off <= 16; off += 4) begin
            axi_read(5'(off), d);
            total++;
            if (d !== 32'(model_reg(off))) begin
                bad++;
                $display("FAIL reset_mid off=%0h got=%h want=%h", off, d, model_reg(off));
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_ctrl();
        test_wr_basic();
        test_rd_ch1();
        test_overlap();
        test_enable();
        test_saturate();
        test_random();
        test_clear_race();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
